// File: rtl/console_pkg.sv
// Shared definitions for the text-console pipeline: stream field layout,
// colours and screen geometry in character cells.
package console_pkg;

  localparam int STREAM_W = 26;

  // Stream field indices
  localparam int ACTIVE  = 0;
  localparam int VS      = 1;
  localparam int HS      = 2;
  localparam int YC_LSB  = 3;
  localparam int YC_MSB  = 12;
  localparam int XC_LSB  = 13;
  localparam int XC_MSB  = 22;
  localparam int R       = 23;
  localparam int G       = 24;
  localparam int B       = 25;
  localparam int RGB_LSB = 23;
  localparam int RGB_MSB = 25;
  localparam int VGA_MSB = 22;
  localparam int VGA_W   = 23;

  // Colours, {B,G,R}
  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_BLUE  = 3'b100;

  localparam int screenW = 40;
  localparam int screenH = 30;

endpackage

// File: rtl/console_blink_timer.sv
// Cursor blink timer: counts VS rising edges and toggles blink_phase every
// BLINK_FRAMES frames. blink_phase comes out of reset high.
module console_blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic px_clk,
  input  logic rst_n,
  input  logic vs,
  output logic blink_phase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             vs_r;
  logic [CNT_W-1:0] cnt_r;
  logic             tick_s;

  assign tick_s = vs & ~vs_r;

  // VS history, frame counter and blink phase
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_r        <= 1'b0;
      cnt_r       <= '0;
      blink_phase <= 1'b1;
    end else begin
      vs_r <= vs;
      if (tick_s) begin
        if (cnt_r == CNT_LAST) begin
          cnt_r       <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/console_glyph_render.sv
// Glyph renderer: 3-stage pipeline fetching glyph rows and painting FG/BG
// with a blinking block cursor. CONSOLE_GRID_EN adds a blue cell grid.
module console_glyph_render
  import console_pkg::*;
#(
  parameter int         size         = 16,
  parameter int         CHAR_W       = 8,
  parameter logic [2:0] FG_RGB       = 3'b010,
  parameter logic [2:0] BG_RGB       = 3'b000,
  parameter int         BLINK_FRAMES = 30
) (
  input  logic                     px_clk,
  input  logic                     rst_n,
  input  logic [STREAM_W-1:0]      RGBStr_i,
  input  logic [9:0]               pos_x,
  input  logic [9:0]               pos_y,
  input  logic [CHAR_W-1:0]        char_i,
  output logic [CHAR_W+$clog2(size)-1:0] addr_glyph,
  input  logic [size-1:0]          glyph_row,
  input  logic                     cursor_en,
  input  logic [6:0]               cursor_col,
  input  logic [6:0]               cursor_row,
  output logic [STREAM_W-1:0]      RGBStr_o
);

  localparam int pS = $clog2(size);

  logic [pS-1:0]    row_s, col_s, bit_idx_s;
  logic             hit_s, bit_s, inv_s, blink_phase_s;
  logic [2:0]       rgb_s;
  logic [VGA_W-1:0] stream_s0_r, stream_s1_r;
  logic [pS-1:0]    col_s0_r, col_s1_r;
  logic             hit_s0_r, hit_s1_r;
  logic [2:0]       unused_rgb_s;

  assign unused_rgb_s = RGBStr_i[RGB_MSB:RGB_LSB];

  console_blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .px_clk      (px_clk),
    .rst_n       (rst_n),
    .vs          (RGBStr_i[VS]),
    .blink_phase (blink_phase_s)
  );

  // Cell-relative offsets (modulo size) and full-width cursor cell match
  always_comb begin
    row_s = RGBStr_i[YC_LSB +: pS] - pos_y[pS-1:0];
    col_s = RGBStr_i[XC_LSB +: pS] - pos_x[pS-1:0];
    hit_s = cursor_en && ((pos_x >> pS) == 10'(cursor_col))
                      && ((pos_y >> pS) == 10'(cursor_row));
  end

`ifdef CONSOLE_GRID_EN
  logic grid_s, grid_s0_r, grid_s1_r;
  assign grid_s = (col_s == {pS{1'b1}}) || (row_s == {pS{1'b1}});

  // Grid flag follows the pixel through S0/S1
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      grid_s0_r <= 1'b0;
      grid_s1_r <= 1'b0;
    end else begin
      grid_s0_r <= grid_s;
      grid_s1_r <= grid_s0_r;
    end
  end
`endif

  // S0 (glyph address) and S1 (ROM latency slot) registers
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_glyph  <= '0;
      stream_s0_r <= '0;
      col_s0_r    <= '0;
      hit_s0_r    <= 1'b0;
      stream_s1_r <= '0;
      col_s1_r    <= '0;
      hit_s1_r    <= 1'b0;
    end else begin
      addr_glyph  <= {char_i, row_s};
      stream_s0_r <= RGBStr_i[VGA_MSB:0];
      col_s0_r    <= col_s;
      hit_s0_r    <= hit_s;
      stream_s1_r <= stream_s0_r;
      col_s1_r    <= col_s0_r;
      hit_s1_r    <= hit_s0_r;
    end
  end

  // S2 colour select; ~col is size-1-col since size is a power of two
  always_comb begin
    bit_idx_s = ~col_s1_r;
    bit_s     = glyph_row[bit_idx_s];
    inv_s     = hit_s1_r & blink_phase_s;
    if (stream_s1_r[ACTIVE]) begin
`ifdef CONSOLE_GRID_EN
      if (grid_s1_r) begin
        rgb_s = COL_BLUE;
      end else if (bit_s ^ inv_s) begin
        rgb_s = FG_RGB;
      end else begin
        rgb_s = BG_RGB;
      end
`else
      if (bit_s ^ inv_s) begin
        rgb_s = FG_RGB;
      end else begin
        rgb_s = BG_RGB;
      end
`endif
    end else begin
      rgb_s = COL_BLACK;
    end
  end

  // Registered output stream
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      RGBStr_o <= '0;
    end else begin
      RGBStr_o <= {rgb_s, stream_s1_r};
    end
  end

endmodule
